// File: rtl/bapple_playback_ctrl_pkg.sv
// bapple_pkg: shared types and constants for the playback sequencer and the
// RLE frame decoder.
//   NUM_FRAMES   : frames in the encoded video
//   FRAME_W      : width of the decoder's frame index
//   play_state_t : playback sequencer state encoding
package bapple_pkg;

  localparam int NUM_FRAMES = 3286;
  localparam int FRAME_W    = $clog2(NUM_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_STEP    = 3'd3,
    ST_RESTART = 3'd4,
    ST_DONE    = 3'd5
  } play_state_t;

endpackage

// File: rtl/bapple_playback_ctrl_if.sv
// bapple_playback_ctrl_if: bundle between the timing generator / button logic
// / decoder (master side) and the playback sequencer (slave side).
//   vsync, btn_play, btn_step, btn_restart, loop_en, rate_div, frame_num : to sequencer
//   dec_vsync, dec_rst, playing, done                                     : from sequencer
//   ffwd : fast-forward level, present only when BAPPLE_PLAYBACK_FFWD_EN is defined
interface bapple_playback_ctrl_if
  import bapple_pkg::*;
#(
  parameter int DIV_W = 4
);
  logic               vsync;
  logic               btn_play;
  logic               btn_step;
  logic               btn_restart;
  logic               loop_en;
  logic [DIV_W-1:0]   rate_div;
  logic [FRAME_W-1:0] frame_num;
`ifdef BAPPLE_PLAYBACK_FFWD_EN
  logic               ffwd;
`endif
  logic               dec_vsync;
  logic               dec_rst;
  logic               playing;
  logic               done;

  modport master (
    output vsync, btn_play, btn_step, btn_restart, loop_en, rate_div, frame_num,
`ifdef BAPPLE_PLAYBACK_FFWD_EN
    output ffwd,
`endif
    input  dec_vsync, dec_rst, playing, done
  );

  modport slave (
    input  vsync, btn_play, btn_step, btn_restart, loop_en, rate_div, frame_num,
`ifdef BAPPLE_PLAYBACK_FFWD_EN
    input  ffwd,
`endif
    output dec_vsync, dec_rst, playing, done
  );
endinterface

// File: rtl/bapple_playback_ctrl_edge_det.sv
// bapple_edge_det: 1-bit rising-edge detector. The previous level is
// registered every cycle; rise_o is high in the cycle where d_i is high and
// was low on the previous cycle.
//   clk, rst : clock, synchronous active-high reset (previous level -> 0)
//   d_i      : level input, synchronous to clk
//   rise_o   : rising-edge strobe
module bapple_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/bapple_playback_ctrl.sv
// bapple_playback_ctrl: turns raw display vsync into gated advance pulses for
// the RLE decoder, with play/pause/step/restart, a vsync rate divider and
// end-of-video loop/stop handling.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of bapple_playback_ctrl_if (inputs from timing,
//              buttons and decoder; dec_vsync/dec_rst/playing/done out)
//   RST_CYCLES : cycles dec_rst is held during a restart (1..15)
//   DIV_W      : width of rate_div
// Optional: BAPPLE_PLAYBACK_FFWD_EN adds the ffwd level input; while set in
// PLAY every vsync advances the decoder.
//
// state   | meaning
// IDLE    | after reset, decoder held in reset, waiting for play
// PLAY    | advancing once every rate_div+1 vsync edges
// PAUSE   | frozen on the current frame
// STEP    | waiting for the next vsync edge to advance one frame
// RESTART | decoder held in reset for RST_CYCLES cycles, then PLAY
// DONE    | video ended with looping off; decoder shows frame 0
module bapple_playback_ctrl
  import bapple_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int DIV_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bapple_playback_ctrl_if.slave bus
);

  localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES - 1);

  play_state_t        state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         rst_cnt_q, rst_cnt_d;
  logic [FRAME_W-1:0] fn_prev_q;
  logic               dec_vsync_q, dec_vsync_d;
  logic               vs_edge;
  logic               end_evt;
  logic               ffwd_act;

`ifdef BAPPLE_PLAYBACK_FFWD_EN
  assign ffwd_act = bus.ffwd;
`else
  assign ffwd_act = 1'b0;
`endif

  bapple_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.vsync),
    .rise_o (vs_edge)
  );

  // The decoder wrapping back to frame 0 marks the end of the video; the
  // rewind caused by our own restart must not count.
  assign end_evt = (fn_prev_q != '0) && (bus.frame_num == '0) && (state_q != ST_RESTART);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      fn_prev_q   <= '0;
      dec_vsync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      fn_prev_q   <= bus.frame_num;
      dec_vsync_q <= dec_vsync_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    dec_vsync_d = 1'b0;

    if (bus.btn_restart && (state_q != ST_IDLE)) begin
      state_d   = ST_RESTART;
      rst_cnt_d = RST_LOAD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.btn_play) begin
            state_d   = ST_PLAY;
            div_cnt_d = '0;
          end
        end
        ST_PLAY: begin
          if (bus.btn_play) begin
            state_d = ST_PAUSE;
          end else if (end_evt && !bus.loop_en) begin
            state_d = ST_DONE;
          end else if (ffwd_act) begin
            div_cnt_d   = '0;
            dec_vsync_d = vs_edge;
          end else if (vs_edge) begin
            if (div_cnt_q == '0) begin
              dec_vsync_d = 1'b1;
              div_cnt_d   = bus.rate_div;
            end else begin
              div_cnt_d = div_cnt_q - 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.btn_play) begin
            state_d   = ST_PLAY;
            div_cnt_d = '0;
          end else if (bus.btn_step) begin
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          if (end_evt && !bus.loop_en) begin
            state_d = ST_DONE;
          end else if (vs_edge) begin
            dec_vsync_d = 1'b1;
            state_d     = ST_PAUSE;
          end
        end
        ST_RESTART: begin
          if (rst_cnt_q == '0) begin
            state_d   = ST_PLAY;
            div_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.btn_play) begin
            state_d   = ST_RESTART;
            rst_cnt_d = RST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.dec_vsync = dec_vsync_q;
    bus.dec_rst   = (state_q == ST_IDLE) || (state_q == ST_RESTART);
    bus.playing   = (state_q == ST_PLAY);
    bus.done      = (state_q == ST_DONE);
  end

endmodule

// File: doc/bapple_playback_ctrl.md
Name: bapple_playback_ctrl

Overview:
Playback sequencer for the RLE frame decoder. Converts raw display vsync into gated "advance" pulses for the decoder's vsync input, which gives play/pause/single-step/restart control and a programmable frame-rate divider. Watches the decoder's frame_num to detect end-of-video, then loops or stops. Sits between the VGA timing generator, the user button/debounce logic and the decoder.

Parameters:
NUM_FRAMES, 3286, frames in the encoded video; sets FRAME_W = $clog2(NUM_FRAMES)
RST_CYCLES, 4, cycles dec_rst is held high during a restart (1..15)
DIV_W, 4, width of rate_div

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
vsync  in  1  raw vsync from the timing generator, level, synchronous to clk
btn_play  in  1  1-cycle pulse: toggles play/pause; from IDLE or DONE it starts playback
btn_step  in  1  1-cycle pulse: advance exactly one frame (honoured only in PAUSE)
btn_restart  in  1  1-cycle pulse: rewind the decoder to frame 0
loop_en  in  1  1 = wrap at end of video, 0 = stop in DONE
rate_div  in  DIV_W  advance once every rate_div+1 vsync rising edges
frame_num  in  FRAME_W  current frame index reported by the decoder
dec_vsync  out  1  1-cycle advance pulse to the decoder's vsync input
dec_rst  out  1  decoder synchronous reset
playing  out  1  high in PLAY
done  out  1  high in DONE

Behaviour:
- Only one clock and one reset. Reset is synchronous and active-high.
- Reset values: state=IDLE, dec_vsync=0, dec_rst=1, playing=0, done=0, div_cnt=0, vs_prev=0, fn_prev=0.
- vsync edge: vs_edge = vsync & ~vs_prev, with vs_prev registered every cycle.
- dec_vsync is registered. It is high for exactly one cycle, on the cycle after the qualifying vs_edge. It is never high on two consecutive cycles.
- States are IDLE, PLAY, PAUSE, STEP, RESTART, DONE (enum, 3 bits).
- IDLE: dec_rst=1. btn_play goes to PLAY, and dec_rst=0 from the next cycle.
- PLAY:
  - On vs_edge with div_cnt==0: issue dec_vsync and reload div_cnt=rate_div. rate_div is sampled only at reload.
  - On vs_edge with div_cnt!=0: div_cnt-1.
  - btn_play goes to PAUSE.
- Entering PLAY from any state sets div_cnt=0, so the first vs_edge advances.
- PAUSE:
  - No dec_vsync.
  - btn_play goes to PLAY.
  - btn_step goes to STEP.
- STEP: waits for the next vs_edge, issues one dec_vsync regardless of div_cnt, then returns to PAUSE. btn_play in STEP is ignored.
- RESTART:
  - dec_rst=1 for RST_CYCLES cycles, tracked by an internal counter.
  - Then dec_rst=0 and go to PLAY.
  - Entered from any state except IDLE on btn_restart.
  - Entered from DONE on btn_play.
  - vs_edge is ignored while in RESTART.
- End detection:
  - fn_prev is registered each cycle.
  - end_evt = (fn_prev != 0) && (frame_num == 0) && state != RESTART.
  - In PLAY or STEP: loop_en=1 continues with no action; loop_en=0 goes to DONE.
- DONE:
  - done=1 and dec_vsync suppressed.
  - The decoder is not reset; it shows frame 0.
- Priority when pulses coincide in the same cycle: btn_restart > btn_play > btn_step > end_evt > vs_edge handling.
- playing and done are decoded from the registered state; there are no combinational paths from inputs to outputs.
- rate_div=0 means every vsync. rate_div=15 means every 16th vsync.

Optional Feature:
Macro BAPPLE_PLAYBACK_FFWD_EN.
- Defined:
  - Adds input ffwd (1 bit, level).
  - In PLAY with ffwd=1, every vs_edge issues dec_vsync and div_cnt is held at 0.
  - Releasing ffwd resumes normal division on the next vs_edge.
- Undefined: the port is absent and the divider is always applied.

Decomposition:
- Package bapple_pkg holds:
  - NUM_FRAMES
  - FRAME_W
  - typedef play_state_t, the state enum
- Sub-module bapple_edge_det: 1-bit registered rising-edge detector with synchronous reset. It is used for vs_edge and is reusable by the decoder.

Test Plan:
- Reset, then btn_play, rate_div=0, 5 vsync pulses -> 5 dec_vsync pulses, each 1 cycle wide, each one cycle after its vsync rising edge; dec_rst low from the cycle after btn_play.
- PLAY, rate_div=2, 9 vsyncs -> dec_vsync on vsyncs 1, 4, 7 only; change rate_div to 0 mid-run -> takes effect after the next reload.
- btn_play (PAUSE), 3 vsyncs -> no dec_vsync; btn_step, then 2 vsyncs -> exactly 1 dec_vsync, state back to PAUSE.
- loop_en=0, model frame_num 3285->0 -> done=1 and no further dec_vsync; btn_play -> dec_rst high 4 cycles, then PLAY.
- btn_restart and btn_play in the same cycle during PLAY -> RESTART wins: dec_rst high for 4 cycles, then PLAY with the first vsync advancing; frame_num 7->0 during RESTART raises no end_evt.
- (FFWD_EN) rate_div=3, ffwd=1, 4 vsyncs -> 4 dec_vsync; ffwd=0 -> next advance on vsync 1, then every 4th.
